// File: rtl/seg7_pkg.sv
// Shared 7-segment constants (bit 6 = a ... bit 0 = g, active-high) and
// the receive-side state encoding.
package seg7_pkg;

    localparam int SEG_A = 6;
    localparam int SEG_B = 5;
    localparam int SEG_C = 4;
    localparam int SEG_D = 3;
    localparam int SEG_E = 2;
    localparam int SEG_F = 1;
    localparam int SEG_G = 0;

    localparam logic [6:0] SEG_BLANK = 7'h00;

    localparam logic [6:0] SEG_CODE [0:7] = '{
        7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70
    };

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } seg7_rx_state_t;

endpackage

// File: rtl/seg7_pattern_lookup.sv
// Combinational reverse lookup: segment pattern -> 3-bit code.
// hit is set only for one of the eight legal glyphs; blank flags all-off.
module seg7_pattern_lookup
    import seg7_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       hit,
    output logic [2:0] code,
    output logic       blank
);

    always_comb begin
        hit  = 1'b0;
        code = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (pattern == SEG_CODE[i]) begin
                hit  = 1'b1;
                code = 3'(i);
            end
        end
    end

    assign blank = (pattern == SEG_BLANK);

endmodule

// File: rtl/seg7_symbol_rx.sv
// Watches a 7-segment drive bus, waits for a stable pattern, decodes it and
// hands each newly displayed symbol out once over valid/ready.
module seg7_symbol_rx
    import seg7_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] SEG,
    output logic [2:0] out_code,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err,
    output logic [6:0] err_pattern,
    output logic       ovf,
    input  logic       clr_ovf
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] RUN_MAX = CNT_W'(STABLE_CYCLES);

    logic [6:0]       seg_q;
    logic [CNT_W-1:0] run;
    logic [CNT_W-1:0] run_nxt;
    seg7_rx_state_t   state;
    seg7_rx_state_t   state_nxt;

    logic       changed;
    logic       accept;
    logic       hit;
    logic       blank;
    logic [2:0] code;
    logic       load;
    logic       drop;
    logic       bad;

    seg7_pattern_lookup u_lookup (
        .pattern (SEG),
        .hit     (hit),
        .code    (code),
        .blank   (blank)
    );

    assign changed = (SEG != seg_q);
    assign run_nxt = changed          ? CNT_W'(1) :
                     (run == RUN_MAX) ? run       : run + 1'b1;

    // Accept only on the transition into RUN_MAX, so a saturated blank run
    // in IDLE does not re-fire every cycle.
    assign accept = (run != RUN_MAX) && (run_nxt == RUN_MAX) && (state != LOCKED);

    assign load = accept && hit && (!out_valid || out_ready);
    assign drop = accept && hit && out_valid && !out_ready;
    assign bad  = accept && !hit && !blank;

    always_comb begin
        state_nxt = state;
        if (accept)
            state_nxt = blank ? IDLE : LOCKED;
        else if (changed)
            state_nxt = SETTLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= 7'h00;
            run         <= '0;
            state       <= IDLE;
            out_code    <= 3'd0;
            out_valid   <= 1'b0;
            err         <= 1'b0;
            err_pattern <= 7'h00;
            ovf         <= 1'b0;
        end else begin
            seg_q <= SEG;
            run   <= run_nxt;
            state <= state_nxt;
            err   <= bad;
            if (bad)
                err_pattern <= SEG;
            // A fresh load wins over the handshake clearing valid.
            if (load) begin
                out_code  <= code;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seg7_symbol_rx.sv
// Scenario bench for seg7_symbol_rx: expected codes are queued as stimulus
// is applied and popped by a monitor whenever a handshake completes.
module tb_seg7_symbol_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] SEG = 7'h00;
    logic       out_ready = 1'b0;
    logic       clr_ovf = 1'b0;
    logic [2:0] out_code;
    logic       out_valid;
    logic       err;
    logic [6:0] err_pattern;
    logic       ovf;

    int vectors = 0;
    int miscompares = 0;
    logic [2:0] exp_q[$];

    seg7_symbol_rx #(.STABLE_CYCLES(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .SEG         (SEG),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .err         (err),
        .err_pattern (err_pattern),
        .ovf         (ovf),
        .clr_ovf     (clr_ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] enc(input int c);
        case (c)
            0: return 7'h7E;
            1: return 7'h30;
            2: return 7'h6D;
            3: return 7'h79;
            4: return 7'h33;
            5: return 7'h5B;
            6: return 7'h5F;
            default: return 7'h70;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake seen here completes on the following rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL deliver: unexpected symbol %0d, none expected", out_code);
            end else begin
                logic [2:0] e;
                e = exp_q.pop_front();
                if (out_code !== e) begin
                    miscompares++;
                    $display("FAIL deliver: got code %0d, expected %0d", out_code, e);
                end
            end
        end
    end

    task automatic check_drained(input string name);
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL %s: %0d expected symbols never delivered", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        vectors++;
        if ({out_code, out_valid, err, err_pattern, ovf} !== 13'd0) begin
            miscompares++;
            $display("FAIL reset: code=%0d valid=%b err=%b pat=%h ovf=%b, expected all 0",
                     out_code, out_valid, err, err_pattern, ovf);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        out_ready = 1'b1;
        SEG = enc(1);
        exp_q.push_back(3'd1);
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'(i == 3)) begin
                miscompares++;
                $display("FAIL single_valid edge %0d: valid=%b expected %b", i, out_valid, i == 3);
            end
        end
        check_drained("single");
    endtask

    task automatic test_toggle();
        int nv;
        out_ready = 1'b1;
        for (int p = 0; p < 4; p++) begin
            SEG = (p % 2 == 0) ? enc(0) : enc(6);
            for (int i = 0; i < 2; i++) begin
                tick();
                vectors++;
                if (out_valid !== 1'b0 || err !== 1'b0) begin
                    miscompares++;
                    $display("FAIL toggle: valid=%b err=%b expected 0 0", out_valid, err);
                end
            end
        end
        SEG = enc(2);
        exp_q.push_back(3'd2);
        nv = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (out_valid === 1'b1) nv++;
        end
        vectors++;
        if (nv != 1) begin
            miscompares++;
            $display("FAIL toggle_hold: %0d valid cycles, expected 1", nv);
        end
        check_drained("toggle");
    endtask

    task automatic test_ovf();
        out_ready = 1'b0;
        SEG = enc(3);
        exp_q.push_back(3'd3);
        repeat (6) tick();
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 3'd3 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_first: valid=%b code=%0d ovf=%b expected 1 3 0", out_valid, out_code, ovf);
        end
        SEG = 7'h00;
        repeat (6) tick();
        SEG = enc(4);
        repeat (6) tick();
        vectors++;
        if (ovf !== 1'b1 || out_code !== 3'd3 || out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL ovf_set: ovf=%b code=%0d valid=%b expected 1 3 1", ovf, out_code, out_valid);
        end
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        vectors++;
        if (ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_clear: ovf=%b expected 0", ovf);
        end
        out_ready = 1'b1;
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL ovf_drain: valid=%b expected 0", out_valid);
        end
        check_drained("ovf");
    endtask

    task automatic test_err();
        out_ready = 1'b0;
        SEG = enc(0);
        exp_q.push_back(3'd0);
        repeat (5) tick();
        SEG = 7'h7F;
        for (int i = 0; i < 7; i++) begin
            tick();
            vectors++;
            if (err !== 1'(i == 3)) begin
                miscompares++;
                $display("FAIL err_pulse edge %0d: err=%b expected %b", i, err, i == 3);
            end
        end
        vectors++;
        if (err_pattern !== 7'h7F || out_valid !== 1'b1 || out_code !== 3'd0) begin
            miscompares++;
            $display("FAIL err_hold: pat=%h valid=%b code=%0d expected 7f 1 0",
                     err_pattern, out_valid, out_code);
        end
        out_ready = 1'b1;
        tick();
        check_drained("err");
    endtask

    task automatic test_repeat();
        int nv;
        out_ready = 1'b1;
        exp_q.push_back(3'd7);
        exp_q.push_back(3'd7);
        nv = 0;
        for (int s = 0; s < 3; s++) begin
            SEG = (s == 1) ? 7'h00 : enc(7);
            for (int i = 0; i < 6; i++) begin
                tick();
                if (out_valid === 1'b1) nv++;
            end
        end
        vectors++;
        if (nv != 2) begin
            miscompares++;
            $display("FAIL repeat_blank: %0d deliveries, expected 2", nv);
        end
        nv = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (out_valid === 1'b1) nv++;
        end
        vectors++;
        if (nv != 0) begin
            miscompares++;
            $display("FAIL repeat_held: %0d extra deliveries, expected 0", nv);
        end
        check_drained("repeat");
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b0;
        SEG = enc(6);
        exp_q.push_back(3'd6);
        repeat (5) tick();
        SEG = enc(4);
        repeat (3) tick();
        out_ready = 1'b1;
        exp_q.push_back(3'd4);
        tick();
        vectors++;
        if (out_valid !== 1'b1 || out_code !== 3'd4 || ovf !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_load: valid=%b code=%0d ovf=%b expected 1 4 0", out_valid, out_code, ovf);
        end
        tick();
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_drain: valid=%b expected 0", out_valid);
        end
        check_drained("back_to_back");
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        SEG = enc(5);
        repeat (5) tick();
        SEG = 7'h00;
        tick();
        SEG = enc(5);
        tick();
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_mid_pre: valid=%b expected 1", out_valid);
        end
        rst = 1'b1;
        tick();
        exp_q.delete();
        vectors++;
        if ({out_code, out_valid, err, err_pattern, ovf} !== 13'd0) begin
            miscompares++;
            $display("FAIL rst_mid: code=%0d valid=%b err=%b pat=%h ovf=%b, expected all 0",
                     out_code, out_valid, err, err_pattern, ovf);
        end
        rst = 1'b0;
        out_ready = 1'b1;
        exp_q.push_back(3'd5);
        for (int i = 0; i < 6; i++) begin
            tick();
            vectors++;
            if (out_valid !== 1'(i == 3)) begin
                miscompares++;
                $display("FAIL rst_mid_relock edge %0d: valid=%b expected %b", i, out_valid, i == 3);
            end
        end
        check_drained("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_ovf();
        test_err();
        test_repeat();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
